// File: rtl/cpu_pkg.sv
// Shared types and constants for the 3-bit-opcode accumulator core.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned COUNT_W  = 16;

    localparam logic [8:0] DEFAULT_HALT_INSTR = 9'h1FF;

    typedef enum logic [OPCODE_W-1:0] {
        ADD   = 3'b000,
        ADDI  = 3'b001,
        XOR   = 3'b010,
        LOAD  = 3'b011,
        STORE = 3'b100,
        JUMP  = 3'b101,
        CMP   = 3'b110,
        SHF   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StHalted
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: control, instruction ROM port, issue handshake, branch return and status.
interface fetch_unit_if import cpu_pkg::*; #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned INSTR_W = 9
) ();

    logic                start_i;
    logic                imem_en_o;
    logic [PC_W-1:0]     imem_addr_o;
    logic [INSTR_W-1:0]  imem_rdata_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [INSTR_W-1:0]  out_instr_o;
    opcode_t             out_opcode_o;
    logic [PC_W-1:0]     out_pc_o;
    logic                branch_taken_i;
    logic [PC_W-1:0]     branch_target_i;
    logic                done_o;
    logic [COUNT_W-1:0]  instr_count_o;

    modport master (
        input  start_i, imem_rdata_i, out_ready_i, branch_taken_i, branch_target_i,
        output imem_en_o, imem_addr_o, out_valid_o, out_instr_o, out_opcode_o, out_pc_o,
               done_o, instr_count_o
    );

    modport slave (
        output start_i, imem_rdata_i, out_ready_i, branch_taken_i, branch_target_i,
        input  imem_en_o, imem_addr_o, out_valid_o, out_instr_o, out_opcode_o, out_pc_o,
               done_o, instr_count_o
    );

endinterface

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             incr_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: sequences the PC over a synchronous ROM, issues each word over
// valid/ready, applies branch redirects at handshake and stops on the HALT word.
module fetch_unit import cpu_pkg::*; #(
    parameter int unsigned        PC_W       = 10,
    parameter int unsigned        INSTR_W    = 9,
    parameter logic [PC_W-1:0]    START_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(DEFAULT_HALT_INSTR)
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    out_pc_q;
    logic [INSTR_W-1:0] instr_q;

    logic handshake;
    logic is_halt;
    logic launch;

    assign handshake = (state_q == StIssue) && bus.out_ready_i;
    assign is_halt   = (instr_q == HALT_INSTR);
    // start only matters when no program is in flight
    assign launch    = bus.start_i && ((state_q == StIdle) || (state_q == StHalted));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (launch) state_d = StFetch;
            StFetch:  state_d = StWait;
            StWait:   state_d = StIssue;
            StIssue:  if (handshake) state_d = is_halt ? StHalted : StFetch;
            StHalted: if (launch) state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.imem_en_o    = (state_q == StFetch);
        bus.out_valid_o  = (state_q == StIssue);
        bus.done_o       = (state_q == StHalted);
        bus.imem_addr_o  = pc_q;
        bus.out_instr_o  = instr_q;
        bus.out_opcode_o = opcode_t'(instr_q[INSTR_W-1 -: OPCODE_W]);
        bus.out_pc_o     = out_pc_q;
    end

    always_comb begin
        pc_d = pc_q;
        if (launch) begin
            pc_d = START_PC;
        end else if (handshake && !is_halt) begin
            pc_d = bus.branch_taken_i ? bus.branch_target_i : pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= START_PC;
            instr_q  <= '0;
            out_pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (state_q == StWait) begin
                instr_q  <= bus.imem_rdata_i;
                out_pc_q <= pc_q;
            end
        end
    end

    sat_counter #(
        .Width (COUNT_W)
    ) u_instr_count (
        .clk     (clk),
        .reset   (reset),
        .clear_i (launch),
        .incr_i  (handshake),
        .count_o (bus.instr_count_o)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a program-level reference model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned PcW    = 10;
    localparam int unsigned InstrW = 9;
    localparam logic [8:0]  Halt   = 9'h1FF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(PcW), .INSTR_W(InstrW)) bus ();
    fetch_unit_if #(.PC_W(PcW), .INSTR_W(InstrW)) wbus ();

    fetch_unit #(
        .PC_W       (PcW),
        .INSTR_W    (InstrW),
        .START_PC   (10'h000),
        .HALT_INSTR (Halt)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(
        .PC_W       (PcW),
        .INSTR_W    (InstrW),
        .START_PC   (10'h3FF),
        .HALT_INSTR (Halt)
    ) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus)
    );

    logic       sc_clr, sc_inc;
    logic [2:0] sc_cnt;

    sat_counter #(
        .Width (3)
    ) u_sc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (sc_clr),
        .incr_i  (sc_inc),
        .count_o (sc_cnt)
    );

    logic [8:0] rom [1024];

    always @(posedge clk) begin
        if (bus.imem_en_o)  bus.imem_rdata_i  <= rom[bus.imem_addr_o];
        if (wbus.imem_en_o) wbus.imem_rdata_i <= rom[wbus.imem_addr_o];
    end

    int checks   = 0;
    int failures = 0;
    int unsigned m_pc    = 0;
    int unsigned m_count = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction through issue: optional stall cycles with ignored branch noise, then
    // handshake; the model follows the program rules to predict the next fetch address.
    task automatic issue_one(input int stall, input bit br, input logic [9:0] tgt);
        int n = 0;
        logic [8:0] word;
        while (bus.out_valid_o !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        word = rom[m_pc];
        chk("valid_timeout", 32'(bus.out_valid_o), 32'd1);
        chk("out_pc", 32'(bus.out_pc_o), m_pc);
        chk("out_instr", 32'(bus.out_instr_o), 32'(word));
        chk("out_opcode", 32'(bus.out_opcode_o), 32'(word[8:6]));
        for (int i = 0; i < stall; i++) begin
            bus.out_ready_i     = 1'b0;
            bus.branch_taken_i  = 1'($urandom_range(0, 1));
            bus.branch_target_i = 10'($urandom);
            tick();
            chk("stall_valid", 32'(bus.out_valid_o), 32'd1);
            chk("stall_instr", 32'(bus.out_instr_o), 32'(word));
            chk("stall_en", 32'(bus.imem_en_o), 32'd0);
            chk("stall_addr", 32'(bus.imem_addr_o), m_pc);
        end
        bus.out_ready_i     = 1'b1;
        bus.branch_taken_i  = br;
        bus.branch_target_i = tgt;
        tick();
        bus.out_ready_i    = 1'b0;
        bus.branch_taken_i = 1'b0;
        if (m_count < 65535) m_count++;
        chk("count", 32'(bus.instr_count_o), m_count);
        if (word == Halt) begin
            chk("halt_done", 32'(bus.done_o), 32'd1);
            chk("halt_valid", 32'(bus.out_valid_o), 32'd0);
            chk("halt_en", 32'(bus.imem_en_o), 32'd0);
        end else begin
            m_pc = br ? 32'(tgt) : (m_pc + 1) % 1024;
            chk("next_en", 32'(bus.imem_en_o), 32'd1);
            chk("next_addr", 32'(bus.imem_addr_o), m_pc);
            tick();
            chk("lat_wait", 32'(bus.out_valid_o), 32'd0);
            tick();
            chk("lat_issue", 32'(bus.out_valid_o), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
        reset = 1'b0;
        sc_clr = 1'b0;
        sc_inc = 1'b0;
        bus.start_i = 1'b0;  bus.out_ready_i = 1'b0;
        bus.branch_taken_i = 1'b0;  bus.branch_target_i = '0;
        wbus.start_i = 1'b0; wbus.out_ready_i = 1'b0;
        wbus.branch_taken_i = 1'b0; wbus.branch_target_i = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_en", 32'(bus.imem_en_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_count", 32'(bus.instr_count_o), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr_o), 32'd0);
        chk("rst_instr", 32'(bus.out_instr_o), 32'd0);
        chk("rst_opcode", 32'(bus.out_opcode_o), 32'd0);
        chk("rst_pc", 32'(bus.out_pc_o), 32'd0);
        chk("rst_waddr", 32'(wbus.imem_addr_o), 32'h3FF);
        tick();
        tick();
        reset = 1'b0;

        // Three-word program ending in HALT, ready tied high
        rom[0] = 9'h000; rom[1] = 9'h080; rom[2] = Halt;
        bus.out_ready_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("p_n1_en", 32'(bus.imem_en_o), 32'd1);
        chk("p_n1_valid", 32'(bus.out_valid_o), 32'd0);
        tick();
        chk("p_n2_valid", 32'(bus.out_valid_o), 32'd0);
        tick();
        chk("p_n3_valid", 32'(bus.out_valid_o), 32'd1);
        chk("p_n3_pc", 32'(bus.out_pc_o), 32'd0);
        chk("p_n3_op", 32'(bus.out_opcode_o), 32'(ADD));
        tick();
        chk("p_n4_valid", 32'(bus.out_valid_o), 32'd0);
        chk("p_n4_addr", 32'(bus.imem_addr_o), 32'd1);
        tick(); tick();
        chk("p_n6_valid", 32'(bus.out_valid_o), 32'd1);
        chk("p_n6_pc", 32'(bus.out_pc_o), 32'd1);
        chk("p_n6_op", 32'(bus.out_opcode_o), 32'(XOR));
        tick(); tick(); tick();
        chk("p_n9_valid", 32'(bus.out_valid_o), 32'd1);
        chk("p_n9_pc", 32'(bus.out_pc_o), 32'd2);
        chk("p_n9_op", 32'(bus.out_opcode_o), 32'(SHF));
        chk("p_n9_done", 32'(bus.done_o), 32'd0);
        tick();
        chk("p_n10_done", 32'(bus.done_o), 32'd1);
        chk("p_n10_valid", 32'(bus.out_valid_o), 32'd0);
        chk("p_n10_count", 32'(bus.instr_count_o), 32'd3);
        tick();
        chk("p_done_hold", 32'(bus.done_o), 32'd1);

        // Restart from HALTED, start ignored in WAIT, backpressure with branch noise
        bus.out_ready_i = 1'b0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("rs_done", 32'(bus.done_o), 32'd0);
        chk("rs_count", 32'(bus.instr_count_o), 32'd0);
        chk("rs_en", 32'(bus.imem_en_o), 32'd1);
        chk("rs_addr", 32'(bus.imem_addr_o), 32'd0);
        tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("wstart_valid", 32'(bus.out_valid_o), 32'd1);
        chk("wstart_pc", 32'(bus.out_pc_o), 32'd0);
        m_pc = 0;
        m_count = 0;
        issue_one(5, 1'b0, 10'h000);

        // Asynchronous reset while in ISSUE
        chk("mid_valid_pre", 32'(bus.out_valid_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_addr", 32'(bus.imem_addr_o), 32'd0);
        chk("mid_count", 32'(bus.instr_count_o), 32'd0);
        chk("mid_instr", 32'(bus.out_instr_o), 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("mid_idle", 32'(bus.imem_en_o), 32'd0);

        // PC wrap from entry 0x3FF
        wbus.out_ready_i = 1'b1;
        wbus.start_i = 1'b1;
        tick();
        wbus.start_i = 1'b0;
        chk("wrap_first", 32'(wbus.imem_addr_o), 32'h3FF);
        tick(); tick();
        chk("wrap_pc", 32'(wbus.out_pc_o), 32'h3FF);
        tick();
        chk("wrap_en", 32'(wbus.imem_en_o), 32'd1);
        chk("wrap_addr", 32'(wbus.imem_addr_o), 32'h000);
        wbus.out_ready_i = 1'b0;

        // Branch at pc 4, then randomized program run ending on a HALT word
        rom[2] = 9'h0A5;
        rom[10'h3FE] = Halt;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        m_pc = 0;
        m_count = 0;
        for (int i = 0; i < 4; i++) issue_one($urandom_range(0, 2), 1'b0, 10'h000);
        issue_one(2, 1'b1, 10'h020);
        for (int i = 0; i < 30; i++) begin
            issue_one($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                      10'($urandom_range(0, 10'h3BF)));
        end
        issue_one(0, 1'b1, 10'h3FE);
        issue_one(1, 1'b1, 10'h055);
        chk("end_count", 32'(bus.instr_count_o), m_count);

        // Counter saturation on a narrow instance
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0;
        chk("sc_clear", 32'(sc_cnt), 32'd0);
        sc_inc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("sc_mid", 32'(sc_cnt), 32'd5);
        for (int i = 0; i < 4; i++) tick();
        chk("sc_sat", 32'(sc_cnt), 32'd7);
        sc_inc = 1'b0;
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0;
        chk("sc_reclear", 32'(sc_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
